// File: rtl/box_avg_filter.sv
// Streaming boxcar (moving-average) filter over the last 2**LOG2_LEN signed samples.
// Emits running_sum >>> LOG2_LEN one cycle after each accepted sample.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   clear             synchronous flush of window, sum, count and pending output
//   in_valid/in_ready input handshake; in_data is the signed sample
//   out_valid/out_ready output handshake; out_data is the signed window mean
//   primed            window holds 2**LOG2_LEN real samples
module box_avg_filter #(
   parameter int DATA_W   = 22,
   parameter int LOG2_LEN = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] out_data,
   output logic                     primed
);

   localparam int LEN   = 1 << LOG2_LEN;
   localparam int SUM_W = DATA_W + LOG2_LEN;
   localparam int CNT_W = LOG2_LEN + 1;

   localparam logic [0:0] S_FILL = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   logic signed [DATA_W-1:0] r_buf [LEN];
   logic [LOG2_LEN-1:0]      r_wp;
   logic signed [SUM_W-1:0]  r_sum;
   logic [CNT_W-1:0]         r_cnt;
   logic [0:0]               r_state;
   logic                     r_out_valid;
   logic signed [DATA_W-1:0] r_out_data;

   logic                     w_accept;
   logic signed [DATA_W-1:0] w_old;
   logic signed [SUM_W-1:0]  w_in_ext;
   logic signed [SUM_W-1:0]  w_old_ext;
   logic signed [SUM_W-1:0]  w_sum_nxt;

   assign in_ready  = ~r_out_valid | out_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign primed    = (r_state == S_RUN);

   // clear wins over acceptance, so the sample offered with it is dropped
   assign w_accept  = in_valid & in_ready & ~clear;
   assign w_old     = r_buf[r_wp];
   assign w_in_ext  = {{LOG2_LEN{in_data[DATA_W-1]}}, in_data};
   assign w_old_ext = {{LOG2_LEN{w_old[DATA_W-1]}}, w_old};
   assign w_sum_nxt = r_sum + w_in_ext - w_old_ext;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LEN; i++) r_buf[i] <= '0;
         r_wp        <= '0;
         r_sum       <= '0;
         r_cnt       <= '0;
         r_state     <= S_FILL;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else if (clear) begin
         for (int i = 0; i < LEN; i++) r_buf[i] <= '0;
         r_wp        <= '0;
         r_sum       <= '0;
         r_cnt       <= '0;
         r_state     <= S_FILL;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else if (w_accept) begin
         r_buf[r_wp] <= in_data;
         r_wp        <= r_wp + LOG2_LEN'(1);
         r_sum       <= w_sum_nxt;
         r_out_valid <= 1'b1;
         // upper DATA_W bits of the sum are exactly sum >>> LOG2_LEN
         r_out_data  <= w_sum_nxt[SUM_W-1:LOG2_LEN];
         if (r_state == S_FILL) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(LEN - 1)) r_state <= S_RUN;
         end
      end else if (r_out_valid & out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_box_avg_filter.sv
// Self-checking bench for box_avg_filter.
// Scoreboard of expected means, filled on acceptance and drained on output transfer.
module tb_box_avg_filter;

   logic               clk;
   logic               rst_n;
   logic               clear;
   logic               in_valid;
   logic               in_ready;
   logic signed [21:0] in_data;
   logic               out_valid;
   logic               out_ready;
   logic signed [21:0] out_data;
   logic               primed;

   box_avg_filter #(.DATA_W(22), .LOG2_LEN(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .primed    (primed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int     n_cmp = 0;
   int     n_bad = 0;
   longint q[$];
   longint gm_buf[16];
   int     gm_wp;
   longint gm_sum;
   logic   last_acc;
   logic   last_ir;
   logic   last_pr;
   longint last_od;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic gm_reset();
      for (int i = 0; i < 16; i++) gm_buf[i] = 0;
      gm_wp  = 0;
      gm_sum = 0;
      q.delete();
   endtask

   // one clock: drive at negedge, observe #1 later, update model for next posedge
   task automatic cyc(input logic v, input longint d, input logic rdy, input logic clr);
      logic signed [21:0] xs;
      longint x;
      longint old;
      longint e;
      xs = d[21:0];
      x  = xs;
      @(negedge clk);
      in_valid  = v;
      in_data   = xs;
      out_ready = rdy;
      clear     = clr;
      #1;
      last_ir  = in_ready;
      last_pr  = primed;
      last_acc = v & in_ready & ~clr;
      last_od  = out_data;
      if (out_valid & rdy) begin
         check("sb_size", q.size(), 1);
         if (q.size() > 0) begin
            e = q.pop_front();
            check("sb_data", last_od, e);
         end
      end
      if (clr) begin
         gm_reset();
      end else if (last_acc) begin
         old           = gm_buf[gm_wp];
         gm_buf[gm_wp] = x;
         gm_wp         = (gm_wp + 1) % 16;
         gm_sum        = gm_sum + x - old;
         q.push_back(gm_sum >>> 4);
      end
   endtask

   task automatic feed_chk(input string tag, input longint d, input int n, input longint exp);
      repeat (n) cyc(1'b1, d, 1'b1, 1'b0);
      cyc(1'b0, 0, 1'b1, 1'b0);
      check(tag, last_od, exp);
   endtask

   initial begin
      int     idx;
      int     cnt;
      int     ncyc;
      longint held;

      rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0;
      in_data = '0; out_ready = 1'b1;
      gm_reset();
      #22;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_primed", primed, 0);
      check("rst_in_ready", in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;

      // step response: 1,2,...,16 then 16
      for (int i = 0; i < 20; i++) begin
         cyc(1'b1, 16, 1'b1, 1'b0);
         if (i >= 1) check("step", last_od, (i > 16) ? 16 : i);
         if (i == 15) check("primed_pre", last_pr, 0);
         if (i == 16) check("primed_post", last_pr, 1);
      end

      // impulse
      feed_chk("flush0", 0, 16, 0);
      feed_chk("imp_first", 1600, 1, 100);
      feed_chk("imp_hold", 0, 15, 100);
      feed_chk("imp_gone", 0, 16, 0);

      // signed extremes
      feed_chk("neg_one", -1, 16, -1);
      feed_chk("max", 2097151, 32, 2097151);
      feed_chk("min", -2097152, 32, -2097152);
      for (int i = 0; i < 16; i++)
         cyc(1'b1, (i % 2) ? -2097152 : 2097151, 1'b1, 1'b0);
      cyc(1'b0, 0, 1'b1, 1'b0);
      check("alt", last_od, -1);

      // backpressure: stall 5 clocks, sample retried until accepted
      idx  = 0;
      held = 0;
      for (int c = 0; c < 30; c++) begin
         logic rdy;
         rdy = !(c >= 3 && c <= 7);
         cyc(1'b1, idx * 37 - 500, rdy, 1'b0);
         if (c >= 3 && c <= 7) check("bp_ready", last_ir, 0);
         if (c == 3) held = last_od;
         if (c >= 4 && c <= 7) check("bp_hold", last_od, held);
         if (last_acc) idx++;
      end
      check("bp_count", idx, 25);
      cyc(1'b0, 0, 1'b1, 1'b0);

      // clear at sample 10
      for (int i = 0; i < 9; i++) cyc(1'b1, 7, 1'b1, 1'b0);
      cyc(1'b1, 999, 1'b1, 1'b1);
      @(posedge clk);
      #1;
      check("clr_valid", out_valid, 0);
      check("clr_primed", primed, 0);
      cyc(1'b1, 160, 1'b1, 1'b0);
      cyc(1'b0, 0, 1'b1, 1'b0);
      check("clr_next", last_od, 10);

      // reach RUN then async reset between edges
      for (int i = 0; i < 20; i++) cyc(1'b1, 1000 + i, 1'b1, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", out_valid, 0);
      check("arst_data", out_data, 0);
      check("arst_primed", primed, 0);
      check("arst_ready", in_ready, 1);
      #1 rst_n = 1'b1;
      gm_reset();
      cyc(1'b1, 480, 1'b1, 1'b0);
      cyc(1'b0, 0, 1'b1, 1'b0);
      check("arst_first", last_od, 30);

      // random stream with random valid/ready
      cnt  = 0;
      ncyc = 0;
      while (cnt < 1000 && ncyc < 20000) begin
         cyc(1'($urandom_range(0, 1)), longint'($urandom),
             1'($urandom_range(0, 3) != 0), 1'b0);
         if (last_acc) cnt++;
         ncyc++;
      end
      check("rand_count", cnt, 1000);
      cyc(1'b0, 0, 1'b1, 1'b0);
      cyc(1'b0, 0, 1'b1, 1'b0);
      check("sb_drain", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
